// File: rtl/stream_pkg.sv
// Shared definitions for the byte-stream blocks (source, sink, mux).
// Holds the FSM state encoding and the default stream data width.
// No logic; only types and constants.
package stream_pkg;

  // Default width of the byte stream, shared by source, sink and mux.
  localparam int STREAM_DATA_W = 8;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } src_state_e;

endpackage

// File: rtl/stream_gap_timer.sv
// Inter-packet idle-gap down-counter; flags the final cycle of the gap.
// Latency: expired_o is high GAP_CYCLES-1 cycles after the cycle following load_i.
// No backpressure: counts freely once loaded.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - reload the counter with GAP_CYCLES
//   expired_o   - high during the last idle cycle of the gap
module stream_gap_timer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expired_o
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Loaded on the edge that ends the last beat, so the first gap cycle
  // sees GAP_CYCLES and the last one sees 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(GAP_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired_o = (cnt_q == CW'(1));

endmodule

// File: rtl/stream_source.sv
// Packet traffic generator: bursts of pkt_num packets of pkt_len incrementing bytes.
// Latency: first beat presented the cycle after an accepted start; full throughput.
// Backpressure: ready_in low holds the current beat (valid/data/last) indefinitely.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   start, pkt_len, pkt_num,   - burst request and its configuration,
//   seed                         sampled only when a start is accepted in IDLE
//   busy, done, pkts_sent      - burst status (done is a one-cycle pulse)
//   valid_out, last_out,       - outgoing byte stream, all registered
//   data_out, ready_in
module stream_source
  import stream_pkg::*;
#(
  parameter int DATA_W     = STREAM_DATA_W,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [CNT_W-1:0]  pkt_num,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkts_sent,
  output logic              valid_out,
  output logic              last_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in
);

  src_state_e        state_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  num_q;
  logic [LEN_W-1:0]  beat_q;   // 1-based index of the beat currently presented
  logic [CNT_W-1:0]  sent_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  logic              xfer;
  logic              final_pkt;
  logic              start_ok;
  logic              gap_load;
  logic              gap_expired;

  assign xfer      = valid_q && ready_in;
  // sent_q < num_q always holds while sending, so this is the last packet.
  assign final_pkt = (sent_q == num_q - CNT_W'(1));
  assign start_ok  = start && (pkt_len != '0) && (pkt_num != '0);
  assign gap_load  = (state_q == ST_SEND) && xfer && last_q && !final_pkt;

  stream_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (gap_load),
    .expired_o (gap_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      num_q   <= '0;
      beat_q  <= '0;
      sent_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            len_q   <= pkt_len;
            num_q   <= pkt_num;
            data_q  <= seed;
            sent_q  <= '0;
            beat_q  <= LEN_W'(1);
            last_q  <= (pkt_len == LEN_W'(1));
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (xfer) begin
            // Payload runs on across packet boundaries and wraps naturally.
            data_q <= data_q + DATA_W'(1);
            if (!last_q) begin
              beat_q <= beat_q + LEN_W'(1);
              last_q <= ((beat_q + LEN_W'(1)) == len_q);
            end else begin
              if (sent_q != '1) begin
                sent_q <= sent_q + CNT_W'(1);
              end
              beat_q <= LEN_W'(1);
              if (final_pkt) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else if (GAP_CYCLES == 0) begin
                // Back-to-back: valid stays high, next packet starts now.
                last_q <= (len_q == LEN_W'(1));
              end else begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                state_q <= ST_GAP;
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_expired) begin
            valid_q <= 1'b1;
            last_q  <= (len_q == LEN_W'(1));
            state_q <= ST_SEND;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pkts_sent = sent_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_stream_source.sv
// Directed self-checking bench for stream_source (GAP_CYCLES = 2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every expected value below is hand-derived from the intended behaviour.
module tb_stream_source;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  pkt_len;
  logic [15:0] pkt_num;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [15:0] pkts_sent;
  logic        valid_out;
  logic        last_out;
  logic [7:0]  data_out;
  logic        ready_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] xfer_log[$];

  stream_source #(
    .DATA_W     (8),
    .LEN_W      (8),
    .CNT_W      (16),
    .GAP_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pkt_len   (pkt_len),
    .pkt_num   (pkt_num),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .pkts_sent (pkts_sent),
    .valid_out (valid_out),
    .last_out  (last_out),
    .data_out  (data_out),
    .ready_in  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Log any beat that transfers on the coming edge, then advance one cycle.
  task automatic tick();
    if (valid_out && ready_in) xfer_log.push_back(data_out);
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input string tag, input logic [7:0] d, input logic l);
    check_eq({tag, "_vld"}, {31'd0, valid_out}, 32'd1);
    check_eq({tag, "_dat"}, {24'd0, data_out}, {24'd0, d});
    check_eq({tag, "_lst"}, {31'd0, last_out}, {31'd0, l});
  endtask

  task automatic exp_idle(input string tag);
    check_eq({tag, "_vld"}, {31'd0, valid_out}, 32'd0);
  endtask

  task automatic do_start(input logic [7:0] len, input logic [15:0] num, input logic [7:0] sd);
    start   = 1'b1;
    pkt_len = len;
    pkt_num = num;
    seed    = sd;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    pkt_len  = '0;
    pkt_num  = '0;
    seed     = '0;
    ready_in = 1'b0;
    #3;
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_done",  {31'd0, done}, 32'd0);
    check_eq("rst_pkts",  {16'd0, pkts_sent}, 32'd0);
    check_eq("rst_data",  {24'd0, data_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single packet, constant ready.
    ready_in = 1'b1;
    do_start(8'd4, 16'd1, 8'h10);
    check_eq("sp_busy", {31'd0, busy}, 32'd1);
    exp_beat("sp_b0", 8'h10, 1'b0); tick();
    exp_beat("sp_b1", 8'h11, 1'b0); tick();
    exp_beat("sp_b2", 8'h12, 1'b0); tick();
    exp_beat("sp_b3", 8'h13, 1'b1); tick();
    exp_idle("sp_end");
    check_eq("sp_done", {31'd0, done}, 32'd1);
    check_eq("sp_busy_off", {31'd0, busy}, 32'd0);
    check_eq("sp_pkts", {16'd0, pkts_sent}, 32'd1);
    tick();
    check_eq("sp_done_pulse", {31'd0, done}, 32'd0);
    check_eq("sp_pkts_hold", {16'd0, pkts_sent}, 32'd1);

    // Backpressure: ready 1,0,0,1,1 while sending 3 beats.
    xfer_log.delete();
    ready_in = 1'b1;
    do_start(8'd3, 16'd1, 8'h00);
    exp_beat("bp_b0", 8'h00, 1'b0);
    ready_in = 1'b1; tick();
    exp_beat("bp_b1", 8'h01, 1'b0);
    ready_in = 1'b0; tick();
    exp_beat("bp_stall0", 8'h01, 1'b0);
    ready_in = 1'b0; tick();
    exp_beat("bp_stall1", 8'h01, 1'b0);
    check_eq("bp_busy_stall", {31'd0, busy}, 32'd1);
    ready_in = 1'b1; tick();
    exp_beat("bp_b2", 8'h02, 1'b1);
    ready_in = 1'b1; tick();
    check_eq("bp_done", {31'd0, done}, 32'd1);
    check_eq("bp_nxfer", xfer_log.size(), 32'd3);
    if (xfer_log.size() == 3) begin
      check_eq("bp_x0", {24'd0, xfer_log[0]}, 32'h00);
      check_eq("bp_x1", {24'd0, xfer_log[1]}, 32'h01);
      check_eq("bp_x2", {24'd0, xfer_log[2]}, 32'h02);
    end

    // Multi-packet burst with 2-cycle gaps and payload wrap.
    ready_in = 1'b1;
    do_start(8'd2, 16'd3, 8'hFE);
    exp_beat("mp_p0b0", 8'hFE, 1'b0); tick();
    exp_beat("mp_p0b1", 8'hFF, 1'b1); tick();
    exp_idle("mp_gap0a");
    check_eq("mp_pkts1", {16'd0, pkts_sent}, 32'd1);
    check_eq("mp_busy_gap", {31'd0, busy}, 32'd1);
    tick();
    exp_idle("mp_gap0b"); tick();
    exp_beat("mp_p1b0", 8'h00, 1'b0); tick();
    exp_beat("mp_p1b1", 8'h01, 1'b1); tick();
    exp_idle("mp_gap1a"); tick();
    exp_idle("mp_gap1b"); tick();
    exp_beat("mp_p2b0", 8'h02, 1'b0); tick();
    exp_beat("mp_p2b1", 8'h03, 1'b1); tick();
    exp_idle("mp_end");
    check_eq("mp_done", {31'd0, done}, 32'd1);
    check_eq("mp_pkts3", {16'd0, pkts_sent}, 32'd3);
    tick();

    // Illegal starts: zero length, then zero count.
    do_start(8'd0, 16'd5, 8'h55);
    check_eq("il_len0_busy", {31'd0, busy}, 32'd0);
    exp_idle("il_len0");
    tick();
    check_eq("il_len0_done", {31'd0, done}, 32'd0);
    check_eq("il_len0_pkts", {16'd0, pkts_sent}, 32'd3);
    do_start(8'd3, 16'd0, 8'h55);
    check_eq("il_num0_busy", {31'd0, busy}, 32'd0);
    check_eq("il_num0_pkts", {16'd0, pkts_sent}, 32'd3);
    tick();

    // Start pulsed mid-burst is ignored.
    do_start(8'd2, 16'd1, 8'h40);
    exp_beat("bs_b0", 8'h40, 1'b0);
    start = 1'b1; pkt_len = 8'd5; pkt_num = 16'd9; seed = 8'h99;
    tick();
    start = 1'b0;
    exp_beat("bs_b1", 8'h41, 1'b1); tick();
    check_eq("bs_done", {31'd0, done}, 32'd1);
    check_eq("bs_pkts", {16'd0, pkts_sent}, 32'd1);
    tick();
    check_eq("bs_idle_busy", {31'd0, busy}, 32'd0);
    exp_idle("bs_idle");

    // Asynchronous reset mid-packet, then a clean one-beat burst.
    do_start(8'd4, 16'd2, 8'h20);
    tick();
    exp_beat("rm_b1", 8'h21, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rm_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rm_last",  {31'd0, last_out}, 32'd0);
    check_eq("rm_data",  {24'd0, data_out}, 32'd0);
    check_eq("rm_busy",  {31'd0, busy}, 32'd0);
    check_eq("rm_pkts",  {16'd0, pkts_sent}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_idle("rm_quiet");
    do_start(8'd1, 16'd1, 8'hAA);
    exp_beat("rm_b", 8'hAA, 1'b1);
    check_eq("rm_new_busy", {31'd0, busy}, 32'd1);
    tick();
    exp_idle("rm_new_end");
    check_eq("rm_new_done", {31'd0, done}, 32'd1);
    check_eq("rm_new_pkts", {16'd0, pkts_sent}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_source.md
Name: stream_source

Overview:
- Packet transmitter for the 8-bit valid/last/data/ready byte stream; it drives the upstream side of a sink block.
- On a start pulse it emits a configurable number of packets of configurable length.
- Payload is an incrementing byte pattern from a seed. Packets are separated by a programmable idle gap.
- Used as traffic generator for sink/mux testing and as the reference transmitter in the stream subsystem.

Parameters:
DATA_W, 8, stream data width (payload counter width equals DATA_W)
LEN_W, 8, width of packet-length input (beats per packet)
CNT_W, 16, width of packet-count input and sent-packet counter
GAP_CYCLES, 2, idle cycles with valid_out low between packets (0 = back-to-back)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a burst, honoured only when idle
pkt_len  in  LEN_W  beats per packet, sampled on accepted start
pkt_num  in  CNT_W  packets per burst, sampled on accepted start
seed  in  DATA_W  first payload byte of the burst, sampled on accepted start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after final beat of final packet accepted
pkts_sent  out  CNT_W  packets fully accepted in current/last burst
valid_out  out  1  beat valid
last_out  out  1  marks final beat of a packet, qualified by valid_out
data_out  out  DATA_W  beat payload
ready_in  in  1  downstream accepts beat when high with valid_out

Behaviour:
- Decided: single clock clk; reset rst_n asynchronous, active-low.
- Reset (asserted at any time, including mid-packet): state IDLE; valid_out, last_out, data_out, busy, done = 0; pkts_sent = 0; internal counters = 0. Packet in flight is abandoned, no last_out is emitted.
- All outputs are registered. No combinational path from ready_in to any output.
- Beat transfer: valid_out && ready_in at a rising edge.
- Handshake rules:
  - once valid_out is high, it stays high, with data_out and last_out stable, until the beat transfers;
  - valid_out never depends on ready_in being high first.
- FSM IDLE / SEND / GAP:
  - IDLE: start=1 with pkt_len!=0 and pkt_num!=0 latches config and clears pkts_sent. Next cycle: state SEND, busy=1, valid_out=1, data_out=seed, last_out=(pkt_len==1).
  - IDLE, start with pkt_len==0 or pkt_num==0: ignored; no busy, no done, pkts_sent unchanged.
  - start while busy: ignored, config unchanged.
  - SEND: each transfer increments the payload mod 2^DATA_W (0xFF -> 0x00) and the beat counter. The next beat is presented on the following cycle, giving full throughput under constant ready. last_out is high exactly on beat pkt_len of each packet.
  - SEND, transfer of a last beat: pkts_sent increments.
    - More packets remain, GAP_CYCLES>0: next state GAP, valid_out=0.
    - More packets remain, GAP_CYCLES==0: first beat of next packet presented the next cycle.
    - Final packet: next state IDLE, valid_out=0, busy=0, done=1 for one cycle.
  - GAP: valid_out low for exactly GAP_CYCLES cycles, then SEND with the first beat of the next packet.
- Payload counter runs continuously across packets within a burst; it is not reloaded per packet.
- pkts_sent holds its final value after done until the next accepted start. It saturates at max; it cannot exceed pkt_num.
- ready_in low indefinitely: block stalls with the beat held, busy stays high.

Decomposition:
- Shared package stream_pkg:
  - FSM state enum (IDLE, SEND, GAP);
  - DATA_W default constant, shared with sink and mux.
- One sub-module, stream_gap_timer: down-counter loaded with GAP_CYCLES that flags expiry.
- All remaining logic lives in stream_source.

Test Plan:
- Reset check: hold rst_n=0 mid-sim -> all outputs 0 immediately, without waiting for a clk edge.
- Single packet, ready_in=1: start, pkt_len=4, pkt_num=1, seed=0x10 -> beats 0x10..0x13 on 4 consecutive cycles, last on 0x13, then done pulse, pkts_sent=1.
- Backpressure: pkt_len=3, ready_in pattern 1,0,0,1,1 -> beat 2 held stable during stall; payload 0x00,0x01,0x02 each transferred exactly once.
- Multi-packet with gap: pkt_len=2, pkt_num=3, GAP_CYCLES=2, seed=0xFE -> payload FE,FF | 00,01 | 02,03 (wrap checked); exactly 2 idle cycles between packets; pkts_sent=3.
- Illegal and busy starts:
  - start with pkt_len=0 -> no busy;
  - start pulsed mid-burst -> ignored, original burst completes unchanged.
- Reset mid-packet, then new start with pkt_len=1, pkt_num=1, seed=0xAA -> clean single beat 0xAA with last_out, done pulse.
